seq_mult_issue_ctrl: RTL

Issue/collect controller placed directly upstream of the unsigned 6-bit sequential right-shift multiplier. It accepts operand pairs on a valid/ready stream and buffers them in a 2-entry FIFO. It drives the multiplier's `load`/`a`/`b` inputs, waits out the fixed iteration count, and captures the 13-bit product into a registered valid/ready output. The multiplier shares this block's `clk` and `rst`.

---
 rtl/seq_mult_pkg.sv | 21 ++
 rtl/op_fifo2.sv | 58 +++++
 rtl/seq_mult_issue_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential multiplier issue/collect controller:
// FSM state encoding, default operand width/iteration count, product width.
package seq_mult_pkg;

  localparam int DEFAULT_WIDTH   = 6;
  localparam int DEFAULT_LATENCY = 6;
  localparam int DEFAULT_PROD_W  = 2 * DEFAULT_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RUN     = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  // Product width for a given operand width (one guard bit above 2*w).
  function automatic int prod_width(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/op_fifo2.sv
// Two-entry operand FIFO. No fall-through: a pushed entry shows up on dout
// the cycle after the push. Pointers are 1 bit each, occupancy is a 2-bit count.
module op_fifo2
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [2*WIDTH-1:0] din,
  output logic [2*WIDTH-1:0] dout,
  output logic               full,
  output logic               empty
);

  logic [2*WIDTH-1:0] mem [2];
  logic               rd_ptr;
  logic               wr_ptr;
  logic [1:0]         count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage write; cleared on reset so dout is defined while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointer and occupancy tracking; simultaneous push and pop keeps the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/seq_mult_issue_ctrl.sv
// Issue/collect controller for the 6-bit sequential shift multiplier.
// Buffers operand pairs, pulses the multiplier load, waits out the iteration
// count and captures the product into a registered valid/ready output.
// Optional feature macro: MULT_ZERO_BYPASS_EN (zero operands skip the
// multiplier and produce 0 directly).
module seq_mult_issue_ctrl
  import seq_mult_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               mult_load,
  output logic [WIDTH-1:0]   mult_a,
  output logic [WIDTH-1:0]   mult_b,
  input  logic [2*WIDTH:0]   mult_product,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH:0]   out_product
);

  localparam int PW    = prod_width(WIDTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  state_t             state;
  state_t             state_next;
  logic [2*WIDTH-1:0] fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               load_ops;
  logic               cnt_clear;
  logic               cnt_inc;
  logic               do_capture;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   head_a;
  logic [WIDTH-1:0]   head_b;
  logic [PW-1:0]      capture_value;

  assign in_ready  = !fifo_full;
  assign push      = in_valid && in_ready;
  assign head_a    = fifo_dout[2*WIDTH-1:WIDTH];
  assign head_b    = fifo_dout[WIDTH-1:0];
  assign mult_load = (state == LOAD);

  op_fifo2 #(.WIDTH(WIDTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({in_a, in_b}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef MULT_ZERO_BYPASS_EN
  logic take_zero;
  logic zero_sel;

  // Remember whether the operation in flight is a bypassed zero product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_sel <= 1'b0;
    end else if (pop) begin
      zero_sel <= take_zero;
    end
  end

  assign capture_value = zero_sel ? '0 : mult_product;
`else
  assign capture_value = mult_product;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control strobes for issue, iteration wait and capture.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load_ops   = 1'b0;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    do_capture = 1'b0;
`ifdef MULT_ZERO_BYPASS_EN
    take_zero  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
`ifdef MULT_ZERO_BYPASS_EN
          if ((head_a == '0) || (head_b == '0)) begin
            take_zero  = 1'b1;
            state_next = CAPTURE;
          end else begin
            load_ops   = 1'b1;
            state_next = LOAD;
          end
`else
          load_ops   = 1'b1;
          state_next = LOAD;
`endif
        end
      end
      LOAD: begin
        cnt_clear  = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        if (cnt == CNT_LAST) begin
          state_next = CAPTURE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      CAPTURE: begin
        if (!out_valid || out_ready) begin
          do_capture = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Iteration counter: cleared in LOAD, counts RUN cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt_clear) begin
      cnt <= '0;
    end else if (cnt_inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Operand registers change only when a pair is issued to the multiplier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mult_a <= '0;
      mult_b <= '0;
    end else if (load_ops) begin
      mult_a <= head_a;
      mult_b <= head_b;
    end
  end

  // Output register: load on capture, otherwise drain on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_product <= '0;
    end else if (do_capture) begin
      out_valid   <= 1'b1;
      out_product <= capture_value;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
